// File: rtl/encryption_pkg.sv
// Shared definitions for the transmit-side cipher stages (scytale, zigzag, caesar).
package encryption_pkg;

  localparam int D_WIDTH_DEF       = 8;
  localparam int KEY_WIDTH_DEF     = 8;
  localparam int MAX_NOF_CHARS_DEF = 50;

  localparam logic [7:0] START_ENCRYPTION_TOKEN_DEF = 8'hFA;
  localparam logic [7:0] PAD_CHAR_DEF               = 8'h20;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } enc_state_t;

endpackage

// File: rtl/scytale_addr_gen.sv
// Walks the N x M scytale grid column-major (row index fast) and gives the
// row-major buffer position k of the current cell.
module scytale_addr_gen #(
  parameter int KEY_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_WIDTH-1:0]   n,
  input  logic [KEY_WIDTH-1:0]   m,
  input  logic                   start,
  input  logic                   adv,
  output logic [2*KEY_WIDTH-1:0] k,
  output logic                   last
);

  logic [KEY_WIDTH-1:0] r, c;
  logic                 r_end, c_end;

  assign r_end = (r == n - KEY_WIDTH'(1));
  assign c_end = (c == m - KEY_WIDTH'(1));
  assign last  = r_end && c_end;

  // Full-width product so k never wraps before it is compared with the length.
  assign k = ({{KEY_WIDTH{1'b0}}, r} * {{KEY_WIDTH{1'b0}}, m}) + {{KEY_WIDTH{1'b0}}, c};

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r <= '0;
      c <= '0;
    end else if (adv) begin
      if (r_end) begin
        r <= '0;
        c <= c + KEY_WIDTH'(1);
      end else begin
        r <= r + KEY_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/scytale_encryption.sv
// Scytale encryption: buffers plaintext until the start token, then emits the
// N x M grid column-major, padding cells past the message length.
module scytale_encryption
  import encryption_pkg::*;
#(
  parameter int                   D_WIDTH                = D_WIDTH_DEF,
  parameter int                   KEY_WIDTH              = KEY_WIDTH_DEF,
  parameter int                   MAX_NOF_CHARS          = MAX_NOF_CHARS_DEF,
  parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = D_WIDTH'(START_ENCRYPTION_TOKEN_DEF),
  parameter logic [D_WIDTH-1:0]   PAD_CHAR               = D_WIDTH'(PAD_CHAR_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int LEN_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int IDX_W = $clog2(MAX_NOF_CHARS);

  enc_state_t             state;
  logic                   done;
  logic [KEY_WIDTH-1:0]   n_q, m_q;
  logic [LEN_W-1:0]       len;
  logic [D_WIDTH-1:0]     mem [MAX_NOF_CHARS];

  logic                   is_token, start, store, adv, last;
  logic [2*KEY_WIDTH-1:0] k;
  logic                   in_msg;

  assign is_token = (data_i == START_ENCRYPTION_TOKEN);
  assign start    = (state == COLLECT) && valid_i && is_token;
  assign store    = (state == COLLECT) && valid_i && !is_token &&
                    (len != LEN_W'(MAX_NOF_CHARS));
  assign adv      = (state == EMIT) && !done;
  assign in_msg   = (k < (2*KEY_WIDTH)'(len));

  scytale_addr_gen #(.KEY_WIDTH(KEY_WIDTH)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .n     (n_q),
    .m     (m_q),
    .start (start),
    .adv   (adv),
    .k     (k),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (store) mem[len[IDX_W-1:0]] <= data_i;
  end

  // 'done' marks the trailing cycle that drops busy/valid after the last byte;
  // a zero key sets it at token accept so emission is skipped entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      done    <= 1'b0;
      busy    <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      len     <= '0;
      n_q     <= '0;
      m_q     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          valid_o <= 1'b0;
          data_o  <= '0;
          if (store) len <= len + LEN_W'(1);
          if (start) begin
            n_q   <= key_N;
            m_q   <= key_M;
            done  <= (key_N == '0) || (key_M == '0);
            busy  <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (done) begin
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            len     <= '0;
            done    <= 1'b0;
            state   <= COLLECT;
          end else begin
            valid_o <= 1'b1;
            data_o  <= in_msg ? mem[k[IDX_W-1:0]] : PAD_CHAR;
            if (last) done <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_encryption.sv
// Directed scoreboard bench for scytale_encryption.
module tb_scytale_encryption;

  typedef byte unsigned bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N, key_M;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned sb[$];

  always #5 clk = ~clk;

  scytale_encryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte for every valid output.
  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) chk("unexpected_output", int'(data_o), -1);
      else                chk("data_o", int'(data_o), int'(sb.pop_front()));
    end else if (rst === 1'b0) begin
      chk("data_o_idle_zero", int'(data_o), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic send(input bq_t msg);
    foreach (msg[i]) begin
      valid_i = 1'b1;
      data_i  = msg[i];
      tick();
    end
    valid_i = 1'b0;
  endtask

  // mode 1: drive traffic while busy; mode 2: change keys while busy
  task automatic run(input string name, input bq_t msg, input int n, input int m,
                     input bq_t exp, input int exp_busy, input int mode);
    int cnt;
    key_N = 8'(n);
    key_M = 8'(m);
    send(msg);
    foreach (exp[i]) sb.push_back(exp[i]);
    valid_i = 1'b1;
    data_i  = 8'hFA;
    tick();
    valid_i = 1'b0;
    chk({name, "_valid_t1"}, int'(valid_o), 0);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (mode == 1) begin
        valid_i = 1'b1;
        data_i  = cnt[0] ? 8'hFA : "Q";
      end
      if (mode == 2) begin
        key_N = 8'd7;
        key_M = 8'd1;
      end
      tick();
    end
    valid_i = 1'b0;
    chk({name, "_busy_cycles"}, cnt, exp_busy);
    chk({name, "_valid_after"}, int'(valid_o), 0);
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t ov_msg, ov_exp;
    int  kk;
    rst = 1'b1; valid_i = 1'b0; data_i = '0; key_N = '0; key_M = '0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    rst = 1'b0;
    tick();

    run("basic",    to_q("ABCDEF"),  2, 3, to_q("ADBECF"), 7, 0);
    run("pad",      to_q("HELLO"),   3, 2, to_q("HLOEL "), 7, 1);
    run("trunc",    to_q("ABCDEFG"), 2, 2, to_q("ACBD"),   5, 0);
    run("degen",    to_q("XY"),      2, 0, to_q(""),       1, 0);
    run("emptymsg", to_q(""),        1, 2, to_q("  "),     3, 0);

    // Abort mid-emission after the third output byte.
    key_N = 8'd2; key_M = 8'd3;
    send(to_q("ABCDEF"));
    sb.push_back("A"); sb.push_back("D"); sb.push_back("B");
    valid_i = 1'b1; data_i = 8'hFA;
    tick();
    valid_i = 1'b0;
    tick(); tick(); tick();
    chk("abort_third_valid", int'(valid_o), 1);
    rst = 1'b1;
    tick();
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    chk("abort_drained", sb.size(), 0);

    run("keylatch", to_q("WXYZ"), 2, 2, to_q("WYXZ"), 5, 2);

    for (int i = 1; i <= 55; i++) ov_msg.push_back(8'(i));
    for (int c = 0; c < 11; c++)
      for (int r = 0; r < 5; r++) begin
        kk = r * 11 + c;
        ov_exp.push_back(kk < 50 ? 8'(kk + 1) : 8'h20);
      end
    run("overflow", ov_msg, 5, 11, ov_exp, 56, 0);

    tick(); tick();
    chk("final_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
